// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro: IMEM_FETCH_ALIGN_CHECK_EN (see imem_fetch_ctrl).
package imem_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Wide enough for WAIT_CYCLES up to 15
  localparam int unsigned WAIT_CNT_W = 4;

endpackage

// File: rtl/imem_wait_cnt.sv
// Wait counter for the IM access latency. Counts down from WAIT_CYCLES-1 while
// enabled and pulses o_done in the cycle the IM data is to be sampled.
module imem_wait_cnt
  import imem_fetch_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_done
);

  localparam logic [WAIT_CNT_W-1:0] LOAD = WAIT_CNT_W'(WAIT_CYCLES - 1);

  logic [WAIT_CNT_W-1:0] cnt;

  // Remaining-cycles form of the wait: LOAD here is equivalent to an up-count of 0
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= LOAD;
    end else if (i_clr) begin
      cnt <= LOAD;
    end else if (i_en) begin
      cnt <= (cnt == '0) ? LOAD : cnt - 1'b1;
    end
  end

  assign o_done = i_en && !i_clr && (cnt == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the IM address, waits
// WAIT_CYCLES for IM data, registers the word and offers it to decode over a
// valid/ready handshake. Execute may redirect the PC at any time.
// Optional feature macro: IMEM_FETCH_ALIGN_CHECK_EN -- a misaligned redirect
// raises a sticky o_fault and parks the sequencer until reset. Without it the
// target's low two bits are ignored.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic [31:0] o_im_addr,
  input  logic [31:0] i_im_instr,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_fault
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  fetch_state_t  state;
  logic [AW-1:0] pc;
  logic [AW-1:0] opc;
  logic [AW-1:0] redirect_pc;
  logic          fault_req;
  logic          wait_clr;
  logic          wait_done;
  logic          unused_target_bits;

  // Target reduced modulo MEM_BYTES and forced to a word boundary
  assign redirect_pc = {i_target[AW-1:2], 2'b00};
  assign unused_target_bits = ^{i_target[31:AW], i_target[1:0]};

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  assign fault_req = i_redirect && (i_target[1:0] != 2'b00);
`else
  assign fault_req = 1'b0;
`endif

  assign wait_clr  = i_redirect && (state != FAULT);
  assign o_im_addr = {{(32 - AW){1'b0}}, pc};
  assign o_pc      = {{(32 - AW){1'b0}}, opc};

  imem_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state == FETCH),
    .i_clr  (wait_clr),
    .o_done (wait_done)
  );

  // Fetch FSM with PC and output registers; redirect outranks capture and handshake
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= FETCH;
      pc      <= AW'(RESET_PC);
      opc     <= '0;
      o_instr <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        FETCH, VALID: begin
          if (fault_req) begin
            o_valid <= 1'b0;
            state   <= FAULT;
          end else if (i_redirect) begin
            pc      <= redirect_pc;
            o_valid <= 1'b0;
            state   <= FETCH;
          end else if (state == FETCH) begin
            if (wait_done) begin
              o_instr <= i_im_instr;
              opc     <= pc;
              o_valid <= 1'b1;
              pc      <= pc + AW'(INSTR_BYTES);
              state   <= VALID;
            end
          end else if (i_ready) begin
            o_valid <= 1'b0;
            state   <= FETCH;
          end
        end
        FAULT: begin
          o_valid <= 1'b0;
        end
        default: begin
          o_valid <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

`ifdef IMEM_FETCH_ALIGN_CHECK_EN
  // Sticky fault flag, set by the first misaligned redirect
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_fault <= 1'b0;
    end else if ((state != FAULT) && fault_req) begin
      o_fault <= 1'b1;
    end
  end
`else
  assign o_fault = 1'b0;
`endif

endmodule
